// File: rtl/serial_packet_receiver.sv
`default_nettype none
// ============================================================================
// Module   : serial_packet_receiver
// Brief    : Deframes start/addr/len/payload serial packets into parallel fields.
// Revision : 1.0 - initial release
// ============================================================================
module serial_packet_receiver #(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serin,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0]  len,
  output logic [DATA_W-1:0] data
);

  localparam int c_max_len = (1 << LEN_W) - 1;
  localparam int c_cnt_max = (ADDR_W > LEN_W) ?
                             ((ADDR_W > c_max_len) ? ADDR_W : c_max_len) :
                             ((LEN_W  > c_max_len) ? LEN_W  : c_max_len);
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_addr_end = c_cnt_w'(ADDR_W);
  localparam logic [c_cnt_w-1:0] c_len_end  = c_cnt_w'(LEN_W);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_inc;
  logic [LEN_W-1:0]   w_len_next;

  // The counter is compared after incrementing, so field ends test against the width itself.
  assign w_cnt_inc  = r_cnt + c_cnt_one;
  assign w_len_next = {len[LEN_W-2:0], serin};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      addr    <= '0;
      len     <= '0;
      data    <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!serin) begin
            r_state <= ADDR;
            busy    <= 1'b1;
            r_cnt   <= '0;
            addr    <= '0;
            len     <= '0;
            data    <= '0;
          end
        end
        ADDR: begin
          addr <= {addr[ADDR_W-2:0], serin};
          if (w_cnt_inc == c_addr_end) begin
            r_state <= LEN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        LEN: begin
          len <= w_len_next;
          if (w_cnt_inc == c_len_end) begin
            r_cnt <= '0;
            if (w_len_next == '0) begin
              r_state <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DATA: begin
          data <= {data[DATA_W-2:0], serin};
          if (w_cnt_inc == c_cnt_w'(len)) begin
            r_state <= DONE;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_packet_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_packet_receiver
// Brief    : Directed self-checking bench for serial_packet_receiver.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_packet_receiver;

  logic        clk;
  logic        rst;
  logic        serin;
  logic        busy;
  logic        done;
  logic [1:0]  addr;
  logic [3:0]  len;
  logic [14:0] data;

  int checks;
  int errors;
  int done_cnt;

  serial_packet_receiver #(.ADDR_W(2), .LEN_W(4), .DATA_W(15)) dut (
    .clk   (clk),
    .rst   (rst),
    .serin (serin),
    .busy  (busy),
    .done  (done),
    .addr  (addr),
    .len   (len),
    .data  (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Present one bit, let it be sampled, and settle just after the edge.
  task automatic drive(input logic b);
    serin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0);
    drive(1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (addr !== 2'd0) begin errors++; $display("FAIL reset_addr got %h want 0", addr); end
    checks++; if (len  !== 4'd0) begin errors++; $display("FAIL reset_len got %h want 0", len); end
    checks++; if (data !== 15'd0) begin errors++; $display("FAIL reset_data got %h want 0", data); end
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy cycle %0d got %b want 0", i, busy); end
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL idle_done_count got %0d want 0", done_cnt); end
  endtask

  task automatic test_basic();
    logic [9:0] f;
    int bad;
    int d0;
    f = 10'b0_10_0011_101;
    bad = 0;
    d0 = done_cnt;
    for (int i = 9; i >= 1; i--) begin
      drive(f[i]);
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_busy_window bad cycles %0d want 0", bad); end
    drive(f[0]);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
    checks++; if (addr !== 2'd2) begin errors++; $display("FAIL basic_addr got %h want 2", addr); end
    checks++; if (len !== 4'd3) begin errors++; $display("FAIL basic_len got %h want 3", len); end
    checks++; if (data !== 15'h0005) begin errors++; $display("FAIL basic_data got %h want 0005", data); end
    drive(1'b1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_one_cycle got %b want 0", done); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); end
    drive(1'b1);
  endtask

  task automatic test_zero_len();
    logic [6:0] f;
    int bad;
    f = 7'b0_11_0000;
    bad = 0;
    for (int i = 6; i >= 1; i--) begin
      drive(f[i]);
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL zero_busy_window bad cycles %0d want 0", bad); end
    drive(f[0]);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done); end
    checks++; if (addr !== 2'd3) begin errors++; $display("FAIL zero_addr got %h want 3", addr); end
    checks++; if (len !== 4'd0) begin errors++; $display("FAIL zero_len got %h want 0", len); end
    checks++; if (data !== 15'd0) begin errors++; $display("FAIL zero_data got %h want 0", data); end
    drive(1'b1);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after done %b busy %b want 0 0", done, busy); end
    drive(1'b1);
  endtask

  task automatic test_max_len();
    logic [21:0] f;
    int bad;
    f = {7'b0_01_1111, 15'b101100111000111};
    bad = 0;
    for (int i = 21; i >= 1; i--) begin
      drive(f[i]);
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL max_busy_window bad cycles %0d want 0", bad); end
    drive(f[0]);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL max_done got %b want 1", done); end
    checks++; if (addr !== 2'd1) begin errors++; $display("FAIL max_addr got %h want 1", addr); end
    checks++; if (len !== 4'd15) begin errors++; $display("FAIL max_len got %h want f", len); end
    checks++; if (data !== 15'h59C7) begin errors++; $display("FAIL max_data got %h want 59c7", data); end
    drive(1'b1);
    drive(1'b1);
  endtask

  task automatic test_back_to_back();
    logic [9:0] f1;
    logic [7:0] f2;
    int d0;
    f1 = 10'b0_10_0011_101;
    f2 = 8'b0_01_0001_1;
    d0 = done_cnt;
    for (int i = 9; i >= 0; i--) drive(f1[i]);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", done); end
    drive(1'b0);  // DONE cycle: serin must be ignored
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_gap busy %b done %b want 0 0", busy, done); end
    checks++; if (addr !== 2'd2 || len !== 4'd3 || data !== 15'h0005) begin
      errors++; $display("FAIL b2b_hold addr %h len %h data %h want 2 3 0005", addr, len, data);
    end
    drive(f2[7]);
    checks++; if (busy !== 1'b1 || addr !== 2'd0 || len !== 4'd0 || data !== 15'd0) begin
      errors++; $display("FAIL b2b_second_start busy %b addr %h len %h data %h want 1 0 0 0", busy, addr, len, data);
    end
    for (int i = 6; i >= 0; i--) drive(f2[i]);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b want 1", done); end
    checks++; if (addr !== 2'd1 || len !== 4'd1 || data !== 15'd1) begin
      errors++; $display("FAIL b2b_second_fields addr %h len %h data %h want 1 1 0001", addr, len, data);
    end
    drive(1'b1);
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - d0); end
    drive(1'b1);
  endtask

  task automatic test_reset_mid();
    logic [8:0] hdr;
    logic [8:0] f;
    int d0;
    hdr = 9'b0_11_0101_10;
    f   = 9'b0_10_0010_11;
    d0  = done_cnt;
    for (int i = 8; i >= 0; i--) drive(hdr[i]);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_in_data busy got %b want 1", busy); end
    rst = 1'b1;
    drive(1'b1);
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || addr !== 2'd0 || len !== 4'd0 || data !== 15'd0) begin
      errors++; $display("FAIL mid_cleared busy %b done %b addr %h len %h data %h want all 0", busy, done, addr, len, data);
    end
    for (int i = 0; i < 4; i++) drive(1'b1);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL mid_no_done got %0d want 0", done_cnt - d0); end
    for (int i = 8; i >= 0; i--) drive(f[i]);
    checks++; if (done !== 1'b1 || addr !== 2'd2 || len !== 4'd2 || data !== 15'd3) begin
      errors++; $display("FAIL mid_clean done %b addr %h len %h data %h want 1 2 2 0003", done, addr, len, data);
    end
    drive(1'b1);
    drive(1'b1);
  endtask

  task automatic test_zero_stream();
    int bad;
    int d0;
    bad = 0;
    d0 = done_cnt;
    for (int i = 0; i < 24; i++) begin
      drive(1'b0);
      if (done !== ((i % 8) == 6)) bad++;
      if ((i % 8) == 6 && (addr !== 2'd0 || len !== 4'd0 || data !== 15'd0)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stream_done_pattern bad cycles %0d want 0", bad); end
    checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL stream_done_count got %0d want 3", done_cnt - d0); end
    for (int i = 0; i < 3; i++) drive(1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_idle busy got %b want 0", busy); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    rst      = 1'b1;
    serin    = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_zero_len();
    test_max_len();
    test_back_to_back();
    test_reset_mid();
    test_zero_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
